// File: rtl/dmio_arbiter.sv
// Two-port request/acknowledge arbiter in front of the DMIO data port (data memory + LED/switch window).
// Define DMIO_ARB_RR_EN for round-robin contention; by default port 0 has fixed priority.
module dmio_arbiter #(
  parameter int AW     = 13,
  parameter int DW     = 64,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic [63:0]   dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          dm_wr,
  output logic          dm_rd,
  input  logic [DW-1:0] dm_rdata,
  output logic [1:0]    gnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  // WAIT is entered with RD_LAT-1 remaining cycles; RD_LAT=0 never enters WAIT.
  localparam logic [1:0] CNT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_cnt;

  logic          w_any;
  logic          w_win1;
  logic          w_win_we;
  logic          w_latch;
  logic          w_capture;
  logic          w_to_ack;
  logic          w_wr_nxt;
  logic          w_rd_nxt;
  logic [1:0]    w_gnt_nxt;
  logic [1:0]    w_cnt_nxt;

  assign w_any = r0_req | r1_req;

`ifdef DMIO_ARB_RR_EN
  logic r_last;

  // On contention the port that was not served last wins.
  assign w_win1 = r1_req & (~r0_req | ~r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (r_state == S_ACK) begin
      r_last <= r_owner;
    end
  end
`else
  assign w_win1 = r1_req & ~r0_req;
`endif

  assign w_win_we = w_win1 ? r1_we : r0_we;
  assign dm_addr  = {{(64-AW){1'b0}}, r_addr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_to_ack    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_rd_nxt    = 1'b0;
    w_gnt_nxt   = gnt;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_ISSUE;
          w_latch     = 1'b1;
          w_gnt_nxt   = w_win1 ? 2'b10 : 2'b01;
          w_wr_nxt    = w_win_we;
          w_rd_nxt    = ~w_win_we;
        end
      end
      S_ISSUE: begin
        if (r_we) begin
          w_state_nxt = S_ACK;
          w_to_ack    = 1'b1;
        end else if (RD_LAT == 0) begin
          w_state_nxt = S_ACK;
          w_to_ack    = 1'b1;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_INIT;
          w_rd_nxt    = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_state_nxt = S_ACK;
          w_to_ack    = 1'b1;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
          w_rd_nxt  = 1'b1;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 2'b00;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_wr  <= 1'b0;
      dm_rd  <= 1'b0;
      gnt    <= 2'b00;
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      dm_wr  <= w_wr_nxt;
      dm_rd  <= w_rd_nxt;
      gnt    <= w_gnt_nxt;
      r0_ack <= w_to_ack & ~r_owner;
      r1_ack <= w_to_ack & r_owner;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Transaction latch and per-owner read-data capture; the non-owner's rdata is never touched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      dm_wdata <= '0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      if (w_latch) begin
        r_owner  <= w_win1;
        r_we     <= w_win_we;
        r_addr   <= w_win1 ? r1_addr : r0_addr;
        dm_wdata <= w_win1 ? r1_wdata : r0_wdata;
      end
      if (w_capture) begin
        if (r_owner) begin
          r1_rdata <= dm_rdata;
        end else begin
          r0_rdata <= dm_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmio_arbiter.sv
// Directed bench for dmio_arbiter: a main RD_LAT=2 instance against a small DMIO model,
// plus four side instances (RD_LAT=0..3) for the latency sweep.
module tb_dmio_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [12:0] r0_addr = '0, r1_addr = '0;
  logic [63:0] r0_wdata = '0, r1_wdata = '0;
  logic        r0_ack, r1_ack, dm_wr, dm_rd;
  logic [63:0] r0_rdata, r1_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [1:0]  gnt;

  logic [63:0] mem [0:4095];
  logic [7:0]  led;
  logic [7:0]  sw = 8'h3C;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmio_arbiter #(.AW(13), .DW(64), .RD_LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wr(dm_wr), .dm_rd(dm_rd),
    .dm_rdata(dm_rdata), .gnt(gnt)
  );

  // DMIO model: bit 12 selects the LED/switch window
  assign dm_rdata = dm_addr[12] ? {56'b0, sw} : mem[dm_addr[11:0]];
  always @(posedge clk) begin
    if (dm_wr) begin
      if (dm_addr[12]) led <= dm_wdata[7:0];
      else mem[dm_addr[11:0]] <= dm_wdata;
    end
  end

  // Latency-sweep instances: read data is the running cycle count
  logic        sw_req [4];
  logic        sw_ack [4];
  logic        sw_ack1 [4];
  logic        sw_wr [4];
  logic        sw_rd [4];
  logic [63:0] sw_rdata [4];
  logic [63:0] sw_rdata1 [4];
  logic [63:0] sw_addr [4];
  logic [63:0] sw_wdat [4];
  logic [1:0]  sw_gnt [4];
  logic [63:0] sw_rdin;
  assign sw_rdin = 64'(cyc);

  for (genvar g = 0; g < 4; g++) begin : g_sw
    dmio_arbiter #(.AW(13), .DW(64), .RD_LAT(g)) u_sw (
      .clk(clk), .rst_n(rst_n),
      .r0_req(sw_req[g]), .r0_we(1'b0), .r0_addr(13'h004), .r0_wdata(64'h0),
      .r0_ack(sw_ack[g]), .r0_rdata(sw_rdata[g]),
      .r1_req(1'b0), .r1_we(1'b0), .r1_addr(13'h0), .r1_wdata(64'h0),
      .r1_ack(sw_ack1[g]), .r1_rdata(sw_rdata1[g]),
      .dm_addr(sw_addr[g]), .dm_wdata(sw_wdat[g]), .dm_wr(sw_wr[g]), .dm_rd(sw_rd[g]),
      .dm_rdata(sw_rdin), .gnt(sw_gnt[g])
    );
  end

  typedef struct {
    int          port;
    logic        we;
    logic [12:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
    int          exp_ack;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic req, input logic we,
                          input logic [12:0] a, input logic [63:0] d);
    if (p == 0) begin
      r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
    end else begin
      r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          ack_cyc = -1;
    int          wr_n = 0;
    int          rd_n = 0;
    logic        oth_ack = 1'b0;
    logic [63:0] rd = '0;
    logic [63:0] addr_seen = '0;
    logic [1:0]  gnt1 = '0;
    logic [63:0] oth_before;
    oth_before = (v.port == 0) ? r1_rdata : r0_rdata;
    @(negedge clk);
    set_port(v.port, 1'b1, v.we, v.addr, v.wdata);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) gnt1 = gnt;
      if (dm_wr) begin wr_n++; addr_seen = dm_addr; end
      if (dm_rd) begin rd_n++; addr_seen = dm_addr; end
      if ((v.port == 0) ? r1_ack : r0_ack) oth_ack = 1'b1;
      if ((v.port == 0) ? r0_ack : r1_ack) begin
        ack_cyc = k;
        rd = (v.port == 0) ? r0_rdata : r1_rdata;
        break;
      end
    end
    set_port(v.port, 1'b0, 1'b0, 13'h0, 64'h0);
    chk({tag, " ack_cycle"}, 64'(ack_cyc), 64'(v.exp_ack));
    chk({tag, " gnt"}, 64'(gnt1), (v.port == 0) ? 64'd1 : 64'd2);
    chk({tag, " dm_addr"}, addr_seen, {51'b0, v.addr});
    chk({tag, " dm_wr_cycles"}, 64'(wr_n), v.we ? 64'd1 : 64'd0);
    chk({tag, " dm_rd_cycles"}, 64'(rd_n), v.we ? 64'd0 : 64'd3);
    if (!v.we) chk({tag, " rdata"}, rd, v.exp_rd);
    chk({tag, " other_ack"}, 64'(oth_ack), 64'd0);
    chk({tag, " other_rdata"}, (v.port == 0) ? r1_rdata : r0_rdata, oth_before);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " dm_wr"}, 64'(dm_wr), 64'd0);
    chk({tag, " dm_rd"}, 64'(dm_rd), 64'd0);
    chk({tag, " dm_addr"}, dm_addr, 64'd0);
    chk({tag, " dm_wdata"}, dm_wdata, 64'd0);
    chk({tag, " gnt"}, 64'(gnt), 64'd0);
    chk({tag, " acks"}, {62'b0, r1_ack, r0_ack}, 64'd0);
    chk({tag, " r0_rdata"}, r0_rdata, 64'd0);
    chk({tag, " r1_rdata"}, r1_rdata, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] g_k [13];
    logic       a0_k [13];
    logic       a1_k [13];
    int         cnt0, cnt1, n_own, c0;
    int         own [4];
    int         ackc [4];
    int         rdn [4];
    logic [63:0] rdv [4];

    vecs[0] = '{0, 1'b1, 13'h010,  64'hDEAD_BEEF_0000_0001, 64'h0, 2};
    vecs[1] = '{1, 1'b1, 13'h1000, 64'h0000_0000_0000_00A5, 64'h0, 2};
    vecs[2] = '{1, 1'b0, 13'h1000, 64'h0, 64'h0000_0000_0000_003C, 4};
    vecs[3] = '{0, 1'b0, 13'h010,  64'h0, 64'hDEAD_BEEF_0000_0001, 4};
    vecs[4] = '{1, 1'b1, 13'h0FF,  64'h1122_3344_5566_7788, 64'h0, 2};
    vecs[5] = '{0, 1'b0, 13'h0FF,  64'h0, 64'h1122_3344_5566_7788, 4};
    vecs[6] = '{1, 1'b0, 13'h010,  64'h0, 64'hDEAD_BEEF_0000_0001, 4};
    vecs[7] = '{1, 1'b1, 13'h020,  64'h0000_0000_0000_0077, 64'h0, 2};
    vecs[8] = '{0, 1'b0, 13'h020,  64'h0, 64'h0000_0000_0000_0077, 4};
    for (int g = 0; g < 4; g++) sw_req[g] = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 1) chk("led", 64'(led), 64'hA5);
    end

    // port 1 asks while port 0 sits in WAIT
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 13'h010, 64'h0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) set_port(1, 1'b1, 1'b0, 13'h0FF, 64'h0);
      g_k[k] = gnt; a0_k[k] = r0_ack; a1_k[k] = r1_ack;
      if (r0_ack) set_port(0, 1'b0, 1'b0, 13'h0, 64'h0);
      if (r1_ack) set_port(1, 1'b0, 1'b0, 13'h0, 64'h0);
    end
    cnt0 = 0; cnt1 = 0;
    for (int k = 1; k <= 12; k++) begin
      cnt0 += int'(a0_k[k]); cnt1 += int'(a1_k[k]);
    end
    chk("late r0_ack_k4", 64'(a0_k[4]), 64'd1);
    chk("late gnt_k4", 64'(g_k[4]), 64'd1);
    chk("late gnt_idle_k5", 64'(g_k[5]), 64'd0);
    chk("late gnt_k6", 64'(g_k[6]), 64'd2);
    chk("late r1_ack_k9", 64'(a1_k[9]), 64'd1);
    chk("late r0_ack_count", 64'(cnt0), 64'd1);
    chk("late r1_ack_count", 64'(cnt1), 64'd1);
    chk("late r0_rdata", r0_rdata, 64'hDEAD_BEEF_0000_0001);
    chk("late r1_rdata", r1_rdata, 64'h1122_3344_5566_7788);

    // reset asserted asynchronously while in WAIT
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 13'h0FF, 64'h0000_0000_0000_FFFF);
    repeat (2) @(negedge clk);
    chk("midrst pre dm_rd", 64'(dm_rd), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    set_port(0, 1'b0, 1'b0, 13'h0, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt0 = 0;
    repeat (5) begin
      @(negedge clk);
      cnt0 += int'(r0_ack) + int'(r1_ack);
    end
    chk("midrst no_ack", 64'(cnt0), 64'd0);
    for (int i = 7; i < 9; i++) run_vec(vecs[i], $sformatf("postrst%0d", i));

    // contention straight after reset, both ports reading continuously
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_port(0, 1'b1, 1'b0, 13'h010, 64'h0);
    set_port(1, 1'b1, 1'b0, 13'h0FF, 64'h0);
    n_own = 0;
    for (int k = 1; k <= 40 && n_own < 4; k++) begin
      @(negedge clk);
      if (r0_ack && n_own < 4) begin own[n_own] = 0; n_own++; end
      if (r1_ack && n_own < 4) begin own[n_own] = 1; n_own++; end
    end
    set_port(0, 1'b0, 1'b0, 13'h0, 64'h0);
    set_port(1, 1'b0, 1'b0, 13'h0, 64'h0);
    chk("contend acks", 64'(n_own), 64'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef DMIO_ARB_RR_EN
      chk($sformatf("contend owner%0d", i), 64'(own[i]), 64'(i % 2));
`else
      chk($sformatf("contend owner%0d", i), 64'(own[i]), 64'd0);
`endif
    end

    // latency sweep across RD_LAT=0..3
    @(negedge clk);
    c0 = cyc;
    for (int g = 0; g < 4; g++) begin
      sw_req[g] = 1'b1; ackc[g] = -1; rdn[g] = 0; rdv[g] = '0;
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (sw_rd[g]) rdn[g]++;
        if (sw_ack[g] && ackc[g] < 0) begin
          ackc[g] = k; rdv[g] = sw_rdata[g]; sw_req[g] = 1'b0;
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("sweep%0d ack_cycle", g), 64'(ackc[g]), 64'(2 + g));
      chk($sformatf("sweep%0d dm_rd_cycles", g), 64'(rdn[g]), 64'(g + 1));
      chk($sformatf("sweep%0d rdata", g), rdv[g], 64'(c0 + 1 + g));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmio_arbiter.md
# dmio_arbiter

Two-port request/acknowledge arbiter that shares the single memory-mapped data port (data memory plus LED/switch I/O window) between the CPU load/store path (port 0) and a debug/loader master (port 1). It latches one winning request, drives the memory-side write/read strobes, address and write data for exactly one transaction, and waits a fixed read latency. It then returns an acknowledge and read data to the owner. It sits between both masters and the DMIO block; the address map (bit 12 = I/O window) passes through untouched.

## Interface
Parameters:
- `AW`, 13, requester address width; bit 12 selects the I/O window, bits 11:0 select the data-memory word.
- `DW`, 64, data width.
- `RD_LAT`, 1, cycles from the first `dm_rd` cycle to valid `dm_rdata`; legal range 0..3.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  single clock; all state updates on the rising edge.
  - `rst_n`  in  1  asynchronous, active-low reset.
- Requester ports, for n = 0, 1:
  - `rn_req`  in  1  request; held until `rn_ack`.
  - `rn_we`  in  1  1 = write, 0 = read; stable while `rn_req` is high.
  - `rn_addr`  in  AW  address; stable while `rn_req` is high.
  - `rn_wdata`  in  DW  write data; stable while `rn_req` is high.
  - `rn_ack`  out  1  one-cycle completion pulse.
  - `rn_rdata`  out  DW  read data; valid while `rn_ack` is high and held until the next read completes.
- Memory side:
  - `dm_addr`  out  64  `{51'b0, latched addr}`; drives the DMIO ALU-result input.
  - `dm_wdata`  out  DW  latched write data.
  - `dm_wr`  out  1  write strobe.
  - `dm_rd`  out  1  read enable.
  - `dm_rdata`  in  DW  DMIO read data.
- Status:
  - `gnt`  out  2  one-hot current owner; 0 when idle.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any `req` is high, choose the winner.
  - Latch the winner's `we`, `addr` and `wdata` into `dm_*` registers and set `gnt`.
  - Go to ISSUE; with no request, stay in IDLE.
- ISSUE:
  - Write: `dm_wr`=1 for this cycle only, then go to ACK.
  - Read: `dm_rd`=1. If `RD_LAT`=0, capture `dm_rdata` into the owner's `rdata` this cycle and go to ACK; otherwise go to WAIT with the counter loaded to `RD_LAT`-1.
- WAIT:
  - `dm_rd` stays at 1.
  - The counter decrements each cycle.
  - At 0, capture `dm_rdata`, then go to ACK.
- ACK:
  - Owner's `ack`=1 for one cycle.
  - `dm_rd`=0.
  - Record the owner as last-granted.
  - Clear `gnt`; go to IDLE.
- Arbitration happens only in IDLE. A request arriving mid-transaction waits; it is never dropped or merged.
- The non-owner's `ack` and `rdata` never change.
- `dm_wr` is asserted for exactly one cycle per write, so the LED register and data memory each capture once.
- Requester rule: drop `req`, or present a new transaction, on the edge that ends the `ack` cycle. A `req` still high in the following IDLE cycle is treated as a new request.
- Both requests high in IDLE: resolved by the policy under Configuration.
- Reset (asserted at any time, including mid-transaction):
  - State goes to IDLE immediately.
  - Any in-flight transaction is abandoned with no `ack`.
  - Reset values: `dm_wr`=0, `dm_rd`=0, `dm_addr`=0, `dm_wdata`=0, `gnt`=0, `r0_ack`=`r1_ack`=0, `r0_rdata`=`r1_rdata`=0, last-granted=1.

## Timing
- Write: `req` seen in IDLE at cycle 0 → `dm_wr` at cycle 1 → `ack` at cycle 2.
- Read: `dm_rd` from cycle 1 through cycle 1+`RD_LAT` → `ack` at cycle 2+`RD_LAT`.
- Back-to-back throughput: one write every 3 cycles; one read every 3+`RD_LAT` cycles.
- All outputs are registered; there is no combinational path from `req` to `dm_*` or `ack`.

## Configuration
- `DMIO_ARB_RR_EN` defined: round-robin. On contention, the port that is not last-granted wins. After reset, last-granted=1, so port 0 wins the first contention.
- Undefined: fixed priority. Port 0 always wins contention, and the last-granted register is not built.
- Single-requester behaviour is identical in both builds.

## Test plan
- **Single write.** Port 0 writes addr 0x010, data 0xDEAD_BEEF_0000_0001. Required: `dm_wr` high exactly one cycle with `dm_addr`=0x10; `r0_ack` at cycle 2; a later read of 0x010 returns the same data.
- **I/O window.** Port 1 writes addr 0x1000, data 0xA5. Then port 1 reads 0x1000 with switches = 0x3C and `RD_LAT`=2. Required: LEDs show 0xA5; `r1_rdata`=0x3C with `r1_ack` at cycle 4.
- **Contention.** Both ports issue continuous read requests.
  - With `DMIO_ARB_RR_EN`: grants alternate 0,1,0,1.
  - Without it: port 0 wins every arbitration while its `req` is held.
- **Latency sweep.** For `RD_LAT`=0..3, a read ack arrives at cycle 2+`RD_LAT`, and `dm_rd` is high for `RD_LAT`+1 cycles.
- **Mid-operation reset.** Assert `rst_n`=0 during WAIT. Required: all outputs take their reset values asynchronously, no `ack` is issued, and after release a fresh request completes normally.
- **Late request.** `r1_req` rises while port 0 is in WAIT. Required: port 1 is not granted until the IDLE cycle after `r0_ack`, and `r0_rdata` and `r0_ack` stay unaffected.
